// File: rtl/data_i4_receiver.sv
// data_i4_receiver: data_I4 word receiver with format check, nibble FIFO and valid/ready drain.
// Optional DATA_I4_RX_ERRCNT_EN adds a saturating err_count output.
module data_i4_receiver #(
    parameter int DEPTH       = 8,
    parameter int STOP_ON_ERR = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          in_clock,
    input  logic          in_reset,
    input  logic          in_enable,
    input  logic          in_clear,
    input  logic [15:0]   data_I4,
    input  logic          in_valid,
    output logic [3:0]    out_nibble,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] fifo_count,
    output logic          err_format,
    output logic          err_overflow,
    output logic [1:0]    rx_state
`ifdef DATA_I4_RX_ERRCNT_EN
    ,
    output logic [7:0]    err_count
`endif
);
    typedef enum logic [1:0] {IDLE = 2'b00, RECV = 2'b01, ERROR = 2'b10} state_t;

    logic [1:0]    sync_q;
    logic          rst_n;
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fmt_q, fmt_d, ovf_q, ovf_d;
    logic [3:0]    hold_q, hold_d;
    logic [3:0]    mem_q [DEPTH];
    logic          sample, legal, full, pop, push, fmt_ev, ovf_ev;

    // Assert immediately, release two edges after in_reset rises.
    always_ff @(posedge in_clock or negedge in_reset)
        if (!in_reset) sync_q <= '0;
        else           sync_q <= {sync_q[0], 1'b1};

    assign rst_n  = sync_q[1];
    assign sample = (state_q == RECV) && in_enable && in_valid;
    assign legal  = (data_I4[15:4] == 12'h000);
    assign full   = (count_q == CW'(DEPTH));
    assign pop    = (count_q != '0) && out_ready;
    assign fmt_ev = sample && !legal;
    assign ovf_ev = sample && legal && full && !pop;
    assign push   = sample && legal && (!full || pop) && !in_clear;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        fmt_d    = fmt_q | fmt_ev;
        ovf_d    = ovf_q | ovf_ev;
        hold_d   = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
        unique case (state_q)
            IDLE:    state_d = in_enable ? RECV : IDLE;
            RECV:    state_d = (fmt_ev && STOP_ON_ERR != 0) ? ERROR : (in_enable ? RECV : IDLE);
            default: state_d = state_q;
        endcase
        if (in_clear) begin
            state_d  = in_enable ? RECV : IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            fmt_d    = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge in_clock or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fmt_q    <= 1'b0;
            ovf_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fmt_q    <= fmt_d;
            ovf_q    <= ovf_d;
            hold_q   <= hold_d;
        end

    always_ff @(posedge in_clock)
        if (push) mem_q[wr_ptr_q] <= data_I4[3:0];

    // Head is live while non-empty; otherwise the last head seen is held.
    assign out_valid    = (count_q != '0);
    assign out_nibble   = out_valid ? mem_q[rd_ptr_q] : hold_q;
    assign fifo_count   = count_q;
    assign err_format   = fmt_q;
    assign err_overflow = ovf_q;
    assign rx_state     = state_q;

`ifdef DATA_I4_RX_ERRCNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    always_comb begin
        ecnt_d = ((fmt_ev || ovf_ev) && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
        if (in_clear) ecnt_d = '0;
    end

    always_ff @(posedge in_clock or negedge rst_n)
        if (!rst_n) ecnt_q <= '0;
        else        ecnt_q <= ecnt_d;

    assign err_count = ecnt_q;
`endif
endmodule
